// File: rtl/ime_mode_sched.sv
// Frame-level round-robin scheduler sharing one ime_coreop between NUM_REQ streams.
// Grants one requester per frame, gates its beats onto the core and holds the grant until the last result.
module ime_mode_sched #(
   parameter int NUM_REQ = 4,
   parameter int K_MAX   = 4096,
   parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ-1:0]   req_last,
   input  logic [3*NUM_REQ-1:0] req_mode,
   input  logic [13:0]          cfg_const_cycles,
   output logic                 core_in_valid,
   input  logic                 core_in_ready,
   output logic                 core_in_last,
   output logic                 core_in_poison,
   output logic [7:0]           core_tuser,
   output logic [4:0]           core_mode_onehot,
   output logic [13:0]          core_const_cycles,
   input  logic                 core_out_valid,
   input  logic                 core_out_ready,
   input  logic                 core_out_last,
   output logic [ID_W-1:0]      grant_id,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 err_kmax
);

   localparam int CNT_W = $clog2(K_MAX) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K_MAX - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_DRAIN  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  grant_id_q, grant_id_d;
   logic [4:0]       mode_oh_q, mode_oh_d;
   logic [13:0]      const_q, const_d;
   logic             bad_mode_q, bad_mode_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             frame_done_q, frame_done_d;
   logic             err_kmax_q, err_kmax_d;

   logic            found;
   logic [ID_W-1:0] pick;
   logic [2:0]      sel_mode;
   logic            g_valid;
   logic            g_last;
   logic            at_limit;

   // First requesting index at or above rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      int idx;
      // NOTE: every combinational output gets a default before any branch so no latch is inferred.
      idx   = 0;
      found = 1'b0;
      pick  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr_q) + i) % NUM_REQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
   end

   assign sel_mode = req_mode[3*int'(pick) +: 3];
   assign g_valid  = req_valid[grant_id_q];
   assign g_last   = req_last[grant_id_q];
   assign at_limit = (beat_cnt_q == LAST_CNT);

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      grant_id_d     = grant_id_q;
      mode_oh_d      = mode_oh_q;
      const_d        = const_q;
      bad_mode_d     = bad_mode_q;
      beat_cnt_d     = beat_cnt_q;
      frame_done_d   = 1'b0;
      err_kmax_d     = err_kmax_q;
      req_ready      = '0;
      core_in_valid  = 1'b0;
      core_in_last   = 1'b0;
      core_in_poison = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (found) begin
               grant_id_d = pick;
               bad_mode_d = (sel_mode > 3'd4);
               mode_oh_d  = (sel_mode > 3'd4) ? 5'b0 : (5'b00001 << sel_mode);
               const_d    = cfg_const_cycles;
               beat_cnt_d = '0;
               state_d    = S_STREAM;
            end
         end
         S_STREAM: begin
            core_in_valid         = g_valid;
            req_ready[grant_id_q] = core_in_ready;
            core_in_last          = g_last || at_limit;
            // A forced terminal beat poisons the truncated frame.
            core_in_poison        = bad_mode_q || (at_limit && !g_last);
            if (g_valid && core_in_ready) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (core_in_last) begin
                  state_d = S_DRAIN;
                  if (at_limit && !g_last) err_kmax_d = 1'b1;
               end
            end
         end
         S_DRAIN: begin
            if (core_out_valid && core_out_ready && core_out_last) begin
               frame_done_d = 1'b1;
               rr_ptr_d     = (int'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         grant_id_q   <= '0;
         mode_oh_q    <= '0;
         const_q      <= '0;
         bad_mode_q   <= 1'b0;
         beat_cnt_q   <= '0;
         frame_done_q <= 1'b0;
         err_kmax_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_id_q   <= grant_id_d;
         mode_oh_q    <= mode_oh_d;
         const_q      <= const_d;
         bad_mode_q   <= bad_mode_d;
         beat_cnt_q   <= beat_cnt_d;
         frame_done_q <= frame_done_d;
         err_kmax_q   <= err_kmax_d;
      end
   end

   assign grant_id          = grant_id_q;
   assign core_tuser        = 8'(grant_id_q);
   assign core_mode_onehot  = mode_oh_q;
   assign core_const_cycles = const_q;
   assign busy              = (state_q != S_IDLE);
   assign frame_done        = frame_done_q;
   assign err_kmax          = err_kmax_q;

endmodule

// File: tb/tb_ime_mode_sched.sv
// Directed bench for ime_mode_sched: a table of single-requester frames plus
// hand-written round-robin, overrun, backpressure and mid-frame reset sequences.
module tb_ime_mode_sched;

   localparam int NUM_REQ = 4;
   localparam int K_MAX   = 8;
   localparam int ID_W    = 2;

   logic                 clk;
   logic                 rst_n;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   req_last;
   logic [3*NUM_REQ-1:0] req_mode;
   logic [13:0]          cfg_const_cycles;
   logic                 core_in_valid;
   logic                 core_in_ready;
   logic                 core_in_last;
   logic                 core_in_poison;
   logic [7:0]           core_tuser;
   logic [4:0]           core_mode_onehot;
   logic [13:0]          core_const_cycles;
   logic                 core_out_valid;
   logic                 core_out_ready;
   logic                 core_out_last;
   logic [ID_W-1:0]      grant_id;
   logic                 busy;
   logic                 frame_done;
   logic                 err_kmax;

   int n_checks = 0;
   int n_errors = 0;

   ime_mode_sched #(.NUM_REQ(NUM_REQ), .K_MAX(K_MAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last), .req_mode(req_mode),
      .cfg_const_cycles(cfg_const_cycles),
      .core_in_valid(core_in_valid), .core_in_ready(core_in_ready), .core_in_last(core_in_last),
      .core_in_poison(core_in_poison), .core_tuser(core_tuser), .core_mode_onehot(core_mode_onehot),
      .core_const_cycles(core_const_cycles),
      .core_out_valid(core_out_valid), .core_out_ready(core_out_ready), .core_out_last(core_out_last),
      .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .err_kmax(err_kmax)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         req;
      logic [2:0] mode;
      int         nbeats;
      logic [13:0] cfg;
      logic [4:0] exp_oh;
      logic       exp_poison;
   } frame_vec_t;

   frame_vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (busy) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_grant_timeout"}, 32'(ok), 32'd1);
   endtask

   task automatic drain_and_release(input string name);
      core_out_valid = 1'b1;
      core_out_ready = 1'b1;
      core_out_last  = 1'b1;
      tick();
      core_out_valid = 1'b0;
      core_out_ready = 1'b0;
      core_out_last  = 1'b0;
      check({name, "_frame_done"}, 32'(frame_done), 32'd1);
      check({name, "_idle_after"}, 32'(busy), 32'd0);
   endtask

   // One-beat frame with every requester presenting last; checks owner and ready isolation.
   task automatic rr_frame(input int exp_g);
      wait_grant("rr");
      check("rr_grant_id", 32'(grant_id), 32'(exp_g));
      check("rr_ready_owner", 32'(req_ready), 32'(1 << exp_g));
      check("rr_in_last", 32'(core_in_last), 32'd1);
      tick();
      check("rr_drain_ready", 32'(req_ready), 32'd0);
      drain_and_release("rr");
   endtask

   task automatic do_frame(input frame_vec_t v);
      req_valid = '0;
      req_last  = '0;
      req_mode[3*v.req +: 3] = v.mode;
      cfg_const_cycles = v.cfg;
      req_valid[v.req] = 1'b1;
      core_in_ready = 1'b1;
      wait_grant("tbl");
      check("tbl_grant_id", 32'(grant_id), 32'(v.req));
      check("tbl_tuser", 32'(core_tuser), 32'(v.req));
      check("tbl_onehot", 32'(core_mode_onehot), 32'(v.exp_oh));
      check("tbl_const", 32'(core_const_cycles), 32'(v.cfg));
      for (int b = 0; b < v.nbeats; b++) begin
         req_last[v.req] = (b == v.nbeats - 1);
         #1;
         check("tbl_in_valid", 32'(core_in_valid), 32'd1);
         check("tbl_in_last", 32'(core_in_last), 32'(b == v.nbeats - 1));
         check("tbl_poison", 32'(core_in_poison), 32'(v.exp_poison));
         check("tbl_ready", 32'(req_ready), 32'(1 << v.req));
         tick();
      end
      req_valid = '0;
      req_last  = '0;
      #1;
      check("tbl_drain_busy", 32'(busy), 32'd1);
      check("tbl_drain_valid", 32'(core_in_valid), 32'd0);
      check("tbl_drain_onehot", 32'(core_mode_onehot), 32'(v.exp_oh));
      drain_and_release("tbl");
      tick();
      check("tbl_done_pulse", 32'(frame_done), 32'd0);
   endtask

   initial begin
      int hs;
      rst_n = 1'b0;
      req_valid = '0;
      req_last = '0;
      req_mode = '0;
      cfg_const_cycles = '0;
      core_in_ready = 1'b0;
      core_out_valid = 1'b0;
      core_out_ready = 1'b0;
      core_out_last = 1'b0;

      vecs[0] = '{req: 1, mode: 3'd6, nbeats: 2, cfg: 14'd5,    exp_oh: 5'b00000, exp_poison: 1'b1};
      vecs[1] = '{req: 3, mode: 3'd4, nbeats: 1, cfg: 14'd77,   exp_oh: 5'b10000, exp_poison: 1'b0};
      vecs[2] = '{req: 0, mode: 3'd0, nbeats: 7, cfg: 14'd1,    exp_oh: 5'b00001, exp_poison: 1'b0};
      vecs[3] = '{req: 1, mode: 3'd3, nbeats: 8, cfg: 14'h3fff, exp_oh: 5'b01000, exp_poison: 1'b0};
      vecs[4] = '{req: 0, mode: 3'd5, nbeats: 1, cfg: 14'd9,    exp_oh: 5'b00000, exp_poison: 1'b1};
      vecs[5] = '{req: 2, mode: 3'd2, nbeats: 3, cfg: 14'd0,    exp_oh: 5'b00100, exp_poison: 1'b0};

      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_in_valid", 32'(core_in_valid), 32'd0);
      check("rst_grant", 32'(grant_id), 32'd0);
      check("rst_onehot", 32'(core_mode_onehot), 32'd0);
      check("rst_err", 32'(err_kmax), 32'd0);
      rst_n = 1'b1;
      tick();

      // Round-robin with all requesters permanently valid.
      req_valid = 4'hF;
      req_last = 4'hF;
      core_in_ready = 1'b1;
      rr_frame(0);
      rr_frame(1);
      rr_frame(2);
      rr_frame(3);
      rr_frame(0);
      req_valid = '0;
      req_last = '0;
      tick();

      foreach (vecs[i]) do_frame(vecs[i]);
      check("no_err_at_exact_kmax", 32'(err_kmax), 32'd0);

      // After requester 2 finishes, rr_ptr=3 so 3 wins over 0 and 1.
      req_valid = 4'b1011;
      req_last = 4'hF;
      rr_frame(3);
      req_valid = '0;
      req_last = '0;
      tick();

      // K_MAX overrun: requester 0 never raises last.
      req_mode[2:0] = 3'd1;
      req_valid = 4'b0001;
      core_in_ready = 1'b1;
      wait_grant("ovr");
      for (int b = 0; b < K_MAX; b++) begin
         check("ovr_in_last", 32'(core_in_last), 32'(b == K_MAX - 1));
         check("ovr_poison", 32'(core_in_poison), 32'(b == K_MAX - 1));
         tick();
      end
      check("ovr_err", 32'(err_kmax), 32'd1);
      check("ovr_drain_ready", 32'(req_ready), 32'd0);
      check("ovr_drain_valid", 32'(core_in_valid), 32'd0);
      tick();
      check("ovr_drain_hold", 32'(req_ready), 32'd0);
      check("ovr_drain_busy", 32'(busy), 32'd1);
      drain_and_release("ovr");
      req_valid = '0;
      tick();
      check("ovr_err_sticky", 32'(err_kmax), 32'd1);

      // Backpressure with mid-frame cfg and mode changes.
      req_mode[11:9] = 3'd3;
      cfg_const_cycles = 14'd100;
      req_valid = 4'b1000;
      wait_grant("bp");
      cfg_const_cycles = 14'd200;
      req_mode[11:9] = 3'd0;
      hs = 0;
      for (int c = 0; c < 6; c++) begin
         core_in_ready = c[0];
         req_last[3] = (hs == 2);
         #1;
         check("bp_in_valid", 32'(core_in_valid), 32'd1);
         check("bp_ready", 32'(req_ready), c[0] ? 32'h8 : 32'h0);
         check("bp_const", 32'(core_const_cycles), 32'd100);
         check("bp_onehot", 32'(core_mode_onehot), 32'h08);
         tick();
         if (c[0]) hs++;
      end
      req_valid = '0;
      req_last = '0;
      #1;
      check("bp_in_drain", 32'(core_in_valid), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      drain_and_release("bp");
      tick();

      // Asynchronous reset in the middle of a frame.
      req_mode[5:3] = 3'd2;
      req_valid = 4'b0010;
      core_in_ready = 1'b1;
      wait_grant("mr");
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_ready", 32'(req_ready), 32'd0);
      check("mr_in_valid", 32'(core_in_valid), 32'd0);
      check("mr_err", 32'(err_kmax), 32'd0);
      check("mr_grant", 32'(grant_id), 32'd0);
      tick();
      rst_n = 1'b1;
      req_valid = 4'hF;
      wait_grant("mr_after");
      check("mr_first_grant", 32'(grant_id), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
